// File: rtl/neocore_pkg.sv
// Shared decode-side definitions for the neocore issue path.
//   itype_e      : coarse instruction class carried from decode
//   issue_slot_t : per-slot decode fields held by the issue scheduler
//   NUM_REGS     : architectural register count tracked by the scoreboard
package neocore_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int ITYPE_W  = 3;

    typedef enum logic [ITYPE_W-1:0] {
        ITYPE_ALU    = 3'd0,
        ITYPE_MUL    = 3'd1,
        ITYPE_LOAD   = 3'd2,
        ITYPE_STORE  = 3'd3,
        ITYPE_BRANCH = 3'd4,
        ITYPE_OTHER  = 3'd5
    } itype_e;

    typedef struct packed {
        itype_e           itype;
        logic             mem_rd;
        logic             mem_wr;
        logic             is_branch;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rd2;
        logic             rd_we;
        logic             rd2_we;
    } issue_slot_t;

    // A slot occupies a memory port if it reads or writes memory.
    function automatic logic slot_is_mem(input issue_slot_t s);
        return s.mem_rd | s.mem_wr;
    endfunction

endpackage

// File: rtl/issue_sched_scoreboard.sv
// issue_scoreboard: one LAT_W-bit countdown per architectural register.
// A nonzero counter marks its register as not yet bypassable.
//   clk, rst : clock and synchronous active-high reset (clears all counters)
//   wr_en    : per write port, load the addressed counter this cycle
//   wr_reg   : per write port, register address (r0 is never tracked)
//   wr_lat   : per write port, value to load
//   busy     : per register, counter is nonzero
module issue_scoreboard
    import neocore_pkg::*;
#(
    parameter int NWR   = 4,
    parameter int LAT_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NWR-1:0]                wr_en,
    input  logic [NWR-1:0][REG_W-1:0]     wr_reg,
    input  logic [NWR-1:0][LAT_W-1:0]     wr_lat,
    output logic [NUM_REGS-1:0]           busy
);

    logic [LAT_W-1:0] cnt     [NUM_REGS];
    logic [LAT_W-1:0] cnt_nxt [NUM_REGS];

    // Decrement by default; a load in the same cycle overrides it.
    always_comb begin
        cnt_nxt[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_reg[k] == REG_W'(r))) begin
                    cnt_nxt[r] = wr_lat[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst) begin
                cnt[r] <= '0;
            end else begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: rtl/issue_sched.sv
// issue_sched: in-order issue scheduler for one decode bundle at a time.
// A bundle accepted on one edge is held and issues from the next cycle,
// oldest pending slot first, stopping at the first slot that has a
// scoreboard, intra-group, memory-port or solo-issue conflict.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : bundle handshake, slot 0 oldest
//   in_type..in_lat   : per-slot decode fields
//   flush             : drop the held bundle (scoreboard kept)
//   issue_mask        : slots issued this cycle
//   issue_count       : popcount of issue_mask
//   stall_cycles      : saturating count of held-but-nothing-issued cycles
module issue_sched
    import neocore_pkg::*;
#(
    parameter int ISSUE_W      = 2,
    parameter int MEM_PORTS    = 1,
    parameter int LAT_W        = 3,
    parameter int BRANCH_ALONE = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ISSUE_W-1:0]                in_valid,
    output logic                              in_ready,
    input  logic [ISSUE_W-1:0][ITYPE_W-1:0]   in_type,
    input  logic [ISSUE_W-1:0]                in_mem_rd,
    input  logic [ISSUE_W-1:0]                in_mem_wr,
    input  logic [ISSUE_W-1:0]                in_is_branch,
    input  logic [ISSUE_W-1:0][REG_W-1:0]     in_rs1,
    input  logic [ISSUE_W-1:0][REG_W-1:0]     in_rs2,
    input  logic [ISSUE_W-1:0][REG_W-1:0]     in_rd,
    input  logic [ISSUE_W-1:0][REG_W-1:0]     in_rd2,
    input  logic [ISSUE_W-1:0]                in_rd_we,
    input  logic [ISSUE_W-1:0]                in_rd2_we,
    input  logic [ISSUE_W-1:0][LAT_W-1:0]     in_lat,
    input  logic                              flush,
    output logic [ISSUE_W-1:0]                issue_mask,
    output logic [2:0]                        issue_count,
    output logic [31:0]                       stall_cycles
);

    issue_slot_t [ISSUE_W-1:0]            in_slot;
    issue_slot_t [ISSUE_W-1:0]            slot_p1;
    logic        [ISSUE_W-1:0][LAT_W-1:0] lat_p1;
    logic        [ISSUE_W-1:0]            pend_p1;
    logic                                 accept;

    logic [NUM_REGS-1:0]                  busy;
    logic [ISSUE_W-1:0]                   sel;
    logic [NUM_REGS-1:0]                  grp_dest;
    int                                   mem_cnt;
    int                                   grp_cnt;
    logic                                 grp_solo;
    logic                                 grp_branch;
    logic                                 stop;
    logic                                 hz;
    logic                                 solo;
    logic                                 is_mem;
    issue_slot_t                          s;

    logic [2*ISSUE_W-1:0]                 wr_en;
    logic [2*ISSUE_W-1:0][REG_W-1:0]      wr_reg;
    logic [2*ISSUE_W-1:0][LAT_W-1:0]      wr_lat;

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            in_slot[i].itype     = itype_e'(in_type[i]);
            in_slot[i].mem_rd    = in_mem_rd[i];
            in_slot[i].mem_wr    = in_mem_wr[i];
            in_slot[i].is_branch = in_is_branch[i];
            in_slot[i].rs1       = in_rs1[i];
            in_slot[i].rs2       = in_rs2[i];
            in_slot[i].rd        = in_rd[i];
            in_slot[i].rd2       = in_rd2[i];
            in_slot[i].rd_we     = in_rd_we[i];
            in_slot[i].rd2_we    = in_rd2_we[i];
        end
    end

    // Group formation: walk pending slots oldest-first, accumulating the
    // group's destinations and resource use, and stop at the first conflict
    // so that issue stays strictly in order.
    always_comb begin
        sel        = '0;
        grp_dest   = '0;
        mem_cnt    = 0;
        grp_cnt    = 0;
        grp_solo   = 1'b0;
        grp_branch = 1'b0;
        stop       = 1'b0;
        hz         = 1'b0;
        solo       = 1'b0;
        is_mem     = 1'b0;
        s          = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            s      = slot_p1[i];
            is_mem = slot_is_mem(s);
            solo   = (s.itype == ITYPE_MUL) || ((BRANCH_ALONE != 0) && s.is_branch);
            hz     = 1'b0;
            // grp_dest never has bit 0 set, and busy[0] is always clear,
            // so the nonzero tests below only keep r0 out explicitly.
            if ((s.rs1 != '0) && (busy[s.rs1] || grp_dest[s.rs1])) hz = 1'b1;
            if ((s.rs2 != '0) && (busy[s.rs2] || grp_dest[s.rs2])) hz = 1'b1;
            if (s.rd_we && (s.rd != '0) && (busy[s.rd] || grp_dest[s.rd])) hz = 1'b1;
            if (s.rd2_we && (s.rd2 != '0) && (busy[s.rd2] || grp_dest[s.rd2])) hz = 1'b1;
            if (is_mem && (mem_cnt >= MEM_PORTS)) hz = 1'b1;
            // Nothing joins a group holding a solo slot or a branch, and a
            // solo slot never joins a non-empty group.
            if ((grp_cnt != 0) && (solo || grp_solo || grp_branch)) hz = 1'b1;
            if (pend_p1[i] && !stop) begin
                if (hz) begin
                    stop = 1'b1;
                end else begin
                    sel[i]     = 1'b1;
                    grp_cnt    = grp_cnt + 1;
                    mem_cnt    = is_mem ? mem_cnt + 1 : mem_cnt;
                    grp_solo   = grp_solo | solo;
                    grp_branch = grp_branch | s.is_branch;
                    if (s.rd_we && (s.rd != '0)) grp_dest[s.rd] = 1'b1;
                    if (s.rd2_we && (s.rd2 != '0)) grp_dest[s.rd2] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        issue_mask = (rst || flush) ? '0 : sel;
        issue_count = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            issue_count = issue_count + 3'(issue_mask[i]);
        end
        // Ready when the register is empty or drains completely this cycle.
        in_ready = !rst && !flush && ((pend_p1 & ~issue_mask) == '0);
        accept   = in_ready && (in_valid != '0);
    end

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            wr_en[2*i]    = issue_mask[i] && slot_p1[i].rd_we && (slot_p1[i].rd != '0)
                            && (lat_p1[i] != '0);
            wr_reg[2*i]   = slot_p1[i].rd;
            wr_lat[2*i]   = lat_p1[i];
            wr_en[2*i+1]  = issue_mask[i] && slot_p1[i].rd2_we && (slot_p1[i].rd2 != '0)
                            && (lat_p1[i] != '0);
            wr_reg[2*i+1] = slot_p1[i].rd2;
            wr_lat[2*i+1] = lat_p1[i];
        end
    end

    issue_scoreboard #(
        .NWR   (2*ISSUE_W),
        .LAT_W (LAT_W)
    ) u_sb (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_reg (wr_reg),
        .wr_lat (wr_lat),
        .busy   (busy)
    );

    // ---- decode -> held bundle (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p1 <= '0;
        end else if (flush) begin
            pend_p1 <= '0;
        end else if (accept) begin
            pend_p1 <= in_valid;
        end else begin
            pend_p1 <= pend_p1 & ~issue_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_p1 <= in_slot;
            lat_p1  <= in_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((pend_p1 != '0) && (issue_count == 3'd0)
                     && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched (ISSUE_W=4, MEM_PORTS=1, BRANCH_ALONE=1)
// with a rule-level reference model checked every cycle.
module tb_issue_sched;
    import neocore_pkg::*;

    localparam int W  = 4;
    localparam int LW = 3;
    localparam int MP = 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      flush = 1'b0;
    logic [W-1:0]              in_valid, in_mem_rd, in_mem_wr, in_is_branch;
    logic [W-1:0]              in_rd_we, in_rd2_we;
    logic [W-1:0][ITYPE_W-1:0] in_type;
    logic [W-1:0][REG_W-1:0]   in_rs1, in_rs2, in_rd, in_rd2;
    logic [W-1:0][LW-1:0]      in_lat;
    logic                      in_ready;
    logic [W-1:0]              issue_mask;
    logic [2:0]                issue_count;
    logic [31:0]               stall_cycles;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    issue_sched #(.ISSUE_W(W), .MEM_PORTS(MP), .LAT_W(LW), .BRANCH_ALONE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .in_is_branch(in_is_branch), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_rd2(in_rd2), .in_rd_we(in_rd_we), .in_rd2_we(in_rd2_we),
        .in_lat(in_lat), .flush(flush), .issue_mask(issue_mask),
        .issue_count(issue_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_pend = '0;
    int  m_type[W], m_rs1[W], m_rs2[W], m_rd[W], m_rd2[W], m_lat[W];
    bit  m_rdwe[W], m_rd2we[W], m_mem[W], m_br[W];
    int  m_sb[16];
    logic [31:0] m_stall = '0;
    bit  m_init = 1'b0;

    function automatic bit m_touches(int i, int r);
        if (r == 0) return 1'b0;
        return (m_rs1[i] == r) || (m_rs2[i] == r) || (m_rdwe[i] && m_rd[i] == r)
               || (m_rd2we[i] && m_rd2[i] == r);
    endfunction

    function automatic bit m_solo(int i);
        return (m_type[i] == int'(ITYPE_MUL)) || m_br[i];
    endfunction

    function automatic logic [W-1:0] model_mask();
        logic [W-1:0] mk;
        int grp[$];
        int mem;
        bit ok;
        mk = '0;
        mem = 0;
        for (int i = 0; i < W; i++) begin
            if (!m_pend[i]) continue;
            ok = 1'b1;
            if (m_rs1[i] != 0 && m_sb[m_rs1[i]] > 0) ok = 1'b0;
            if (m_rs2[i] != 0 && m_sb[m_rs2[i]] > 0) ok = 1'b0;
            if (m_rdwe[i] && m_rd[i] != 0 && m_sb[m_rd[i]] > 0) ok = 1'b0;
            if (m_rd2we[i] && m_rd2[i] != 0 && m_sb[m_rd2[i]] > 0) ok = 1'b0;
            foreach (grp[k]) begin
                if (m_rdwe[grp[k]] && m_touches(i, m_rd[grp[k]])) ok = 1'b0;
                if (m_rd2we[grp[k]] && m_touches(i, m_rd2[grp[k]])) ok = 1'b0;
                if (m_solo(grp[k])) ok = 1'b0;
            end
            if (m_solo(i) && grp.size() > 0) ok = 1'b0;
            if (m_mem[i] && mem >= MP) ok = 1'b0;
            if (!ok) break;
            mk[i] = 1'b1;
            grp.push_back(i);
            if (m_mem[i]) mem++;
        end
        return mk;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] mk;
        bit rdy;
        if (rst) begin
            m_pend = '0;
            m_stall = '0;
            for (int r = 0; r < 16; r++) m_sb[r] = 0;
            m_init = 1'b1;
        end else begin
            mk  = flush ? '0 : model_mask();
            rdy = !flush && ((m_pend & ~mk) == '0);
            if (m_pend != '0 && mk == '0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            for (int r = 0; r < 16; r++) if (m_sb[r] > 0) m_sb[r]--;
            for (int i = 0; i < W; i++) begin
                if (mk[i] && m_lat[i] > 0) begin
                    if (m_rdwe[i] && m_rd[i] != 0) m_sb[m_rd[i]] = m_lat[i];
                    if (m_rd2we[i] && m_rd2[i] != 0) m_sb[m_rd2[i]] = m_lat[i];
                end
            end
            if (flush) begin
                m_pend = '0;
            end else if (rdy && in_valid != '0) begin
                m_pend = in_valid;
                for (int i = 0; i < W; i++) begin
                    m_type[i] = int'(in_type[i]);
                    m_rs1[i]  = int'(in_rs1[i]);
                    m_rs2[i]  = int'(in_rs2[i]);
                    m_rd[i]   = int'(in_rd[i]);
                    m_rd2[i]  = int'(in_rd2[i]);
                    m_lat[i]  = int'(in_lat[i]);
                    m_rdwe[i] = in_rd_we[i];
                    m_rd2we[i] = in_rd2_we[i];
                    m_mem[i]  = in_mem_rd[i] | in_mem_wr[i];
                    m_br[i]   = in_is_branch[i];
                end
            end else begin
                m_pend = m_pend & ~mk;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] em;
        bit er;
        em = (rst || flush) ? '0 : model_mask();
        er = !rst && !flush && ((m_pend & ~em) == '0);
        chk("issue_mask", 32'(issue_mask), 32'(em));
        chk("issue_count", 32'(issue_count), 32'($countones(em)));
        chk("in_ready", 32'(in_ready), 32'(er));
        if (m_init && !rst) chk("stall_cycles", stall_cycles, m_stall);
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        in_valid = '0; in_mem_rd = '0; in_mem_wr = '0; in_is_branch = '0;
        in_rd_we = '0; in_rd2_we = '0; in_type = '0; in_rs1 = '0; in_rs2 = '0;
        in_rd = '0; in_rd2 = '0; in_lat = '0;
    endtask

    task automatic set_slot(input int i, input itype_e t, input int rs1, input int rs2,
                            input int rd, input int rd2, input int lat, input bit br);
        in_valid[i]     = 1'b1;
        in_type[i]      = t;
        in_rs1[i]       = REG_W'(rs1);
        in_rs2[i]       = REG_W'(rs2);
        in_rd[i]        = REG_W'(rd);
        in_rd2[i]       = REG_W'(rd2);
        in_rd_we[i]     = 1'b1;
        in_rd2_we[i]    = (rd2 != 0);
        in_lat[i]       = LW'(lat);
        in_mem_rd[i]    = (t == ITYPE_LOAD);
        in_mem_wr[i]    = (t == ITYPE_STORE);
        in_is_branch[i] = br;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            next();
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        clear_in();
    endtask

    task automatic do_reset();
        clear_in();
        flush = 1'b0;
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        clear_in();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;

        // Two independent ALU slots issue together one cycle after acceptance.
        do_reset();
        set_slot(0, ITYPE_ALU, 0, 0, 1, 0, 1, 0);
        set_slot(1, ITYPE_ALU, 0, 0, 2, 0, 1, 0);
        send();
        @(negedge clk);
        chk("pair_mask", 32'(issue_mask), 32'b0011);
        chk("pair_ready", 32'(in_ready), 32'd1);
        next();

        // RAW on r3 (lat 3): three stall cycles, then issue.
        do_reset();
        set_slot(0, ITYPE_ALU, 0, 0, 3, 0, 3, 0);
        send();
        set_slot(0, ITYPE_ALU, 3, 0, 4, 0, 1, 0);
        send();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("raw_stall_mask", 32'(issue_mask), 32'd0);
            next();
        end
        @(negedge clk);
        chk("raw_issue_mask", 32'(issue_mask), 32'b0001);
        chk("raw_stall_cycles", stall_cycles, 32'd3);
        next();

        // Two loads with one memory port.
        do_reset();
        set_slot(0, ITYPE_LOAD, 0, 0, 1, 0, 1, 0);
        set_slot(1, ITYPE_LOAD, 0, 0, 2, 0, 1, 0);
        send();
        @(negedge clk);
        chk("ld_mask0", 32'(issue_mask), 32'b0001);
        chk("ld_ready0", 32'(in_ready), 32'd0);
        next();
        @(negedge clk);
        chk("ld_mask1", 32'(issue_mask), 32'b0010);
        chk("ld_ready1", 32'(in_ready), 32'd1);
        next();

        // Branch issues alone.
        do_reset();
        set_slot(0, ITYPE_ALU, 0, 0, 1, 0, 1, 0);
        set_slot(1, ITYPE_BRANCH, 0, 0, 0, 0, 0, 1);
        set_slot(2, ITYPE_ALU, 0, 0, 2, 0, 1, 0);
        set_slot(3, ITYPE_ALU, 0, 0, 3, 0, 1, 0);
        send();
        @(negedge clk); chk("br_mask0", 32'(issue_mask), 32'b0001); next();
        @(negedge clk); chk("br_mask1", 32'(issue_mask), 32'b0010); next();
        @(negedge clk); chk("br_mask2", 32'(issue_mask), 32'b1100); next();

        // Flush behind an r5 hazard; r5 keeps counting down.
        do_reset();
        set_slot(0, ITYPE_ALU, 0, 0, 5, 0, 7, 0);
        send();
        set_slot(0, ITYPE_ALU, 0, 0, 6, 0, 1, 0);
        set_slot(1, ITYPE_ALU, 5, 0, 7, 0, 1, 0);
        send();
        @(negedge clk); chk("fl_pre_mask", 32'(issue_mask), 32'b0001); next();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_mask", 32'(issue_mask), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd0);
        next();
        flush = 1'b0;
        set_slot(0, ITYPE_ALU, 5, 0, 8, 0, 1, 0);
        @(negedge clk);
        chk("fl_empty_ready", 32'(in_ready), 32'd1);
        chk("fl_empty_mask", 32'(issue_mask), 32'd0);
        next();
        clear_in();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("fl_r5_stall", 32'(issue_mask), 32'd0); next();
        end
        @(negedge clk); chk("fl_r5_issue", 32'(issue_mask), 32'b0001); next();

        // Reset mid-stall, with a competing bundle and flush in the reset cycle.
        do_reset();
        set_slot(0, ITYPE_ALU, 0, 0, 4, 0, 7, 0);
        send();
        set_slot(0, ITYPE_ALU, 4, 0, 5, 0, 1, 0);
        send();
        next();
        rst = 1'b1;
        flush = 1'b1;
        set_slot(0, ITYPE_ALU, 0, 0, 9, 0, 1, 0);
        @(negedge clk);
        chk("rst_mask", 32'(issue_mask), 32'd0);
        chk("rst_count", 32'(issue_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        next();
        rst = 1'b0;
        flush = 1'b0;
        clear_in();
        set_slot(0, ITYPE_ALU, 0, 0, 4, 0, 1, 0);
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_mask", 32'(issue_mask), 32'd0);
        chk("post_rst_stall", stall_cycles, 32'd0);
        next();
        clear_in();
        @(negedge clk); chk("post_rst_issue", 32'(issue_mask), 32'b0001); next();

        // Slot 0 invalid: slot 1 is the oldest pending.
        do_reset();
        set_slot(1, ITYPE_ALU, 0, 0, 1, 0, 1, 0);
        send();
        @(negedge clk); chk("hole_mask", 32'(issue_mask), 32'b0010); next();

        // Intra-group hazard through rd2, then wait on r6.
        set_slot(0, ITYPE_ALU, 0, 0, 0, 6, 2, 0);
        set_slot(1, ITYPE_ALU, 6, 0, 7, 0, 1, 0);
        send();
        @(negedge clk); chk("rd2_mask", 32'(issue_mask), 32'b0001); next();
        repeat (4) next();

        // MUL issues alone; following slot waits on the MUL result.
        set_slot(0, ITYPE_ALU, 0, 0, 2, 0, 1, 0);
        set_slot(1, ITYPE_MUL, 0, 0, 3, 0, 2, 0);
        set_slot(2, ITYPE_ALU, 3, 0, 4, 0, 1, 0);
        send();
        repeat (6) next();

        // WAW on r5, and r0 destinations never tracked.
        set_slot(0, ITYPE_ALU, 0, 0, 5, 0, 3, 0);
        set_slot(1, ITYPE_ALU, 0, 0, 0, 0, 7, 0);
        send();
        set_slot(0, ITYPE_ALU, 0, 0, 5, 0, 1, 0);
        set_slot(1, ITYPE_STORE, 0, 0, 0, 0, 0, 0);
        send();
        repeat (6) next();

        // Back-to-back independent bundles: one per cycle.
        c0 = cyc;
        for (int b = 0; b < 4; b++) begin
            set_slot(0, ITYPE_ALU, 0, 0, b + 1, 0, 0, 0);
            set_slot(1, ITYPE_ALU, 0, 0, b + 6, 0, 0, 0);
            send();
        end
        chk("b2b_cycles", 32'(cyc - c0), 32'd4);
        repeat (4) next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
